// File: rtl/xgmii_rx_pkg.sv
// xgmii_rx_pkg: shared XGMII character codes, error-bit indices and monitor state encoding
package xgmii_rx_pkg;
    localparam logic [7:0] CH_IDLE  = 8'h07;
    localparam logic [7:0] CH_START = 8'hFB;
    localparam logic [7:0] CH_TERM  = 8'hFD;
    localparam logic [7:0] CH_ERR   = 8'hFE;
    localparam logic [7:0] CH_PRE   = 8'h55;
    localparam logic [7:0] CH_SFD   = 8'hD5;
    localparam int ERR_PRE  = 0;
    localparam int ERR_TERM = 1;
    localparam int ERR_CTRL = 2;
    localparam int ERR_RUNT = 3;
    localparam int ERR_LONG = 4;
    typedef enum logic {ST_IDLE, ST_DATA} state_t;
endpackage

// File: rtl/xgmii_term_decode.sv
// xgmii_term_decode: finds the terminate lane of a qword and flags a malformed terminate word
// Ports: data_i/ctrl_i qword in; is_term_o when the lowest control lane holds FD,
// k_o that lane index, term_bad_o when ctrl is not FF<<k or a lane above k is not idle.
module xgmii_term_decode
    import xgmii_rx_pkg::*;
(
    input  logic [63:0] data_i,
    input  logic [7:0]  ctrl_i,
    output logic        is_term_o,
    output logic [2:0]  k_o,
    output logic        term_bad_o
);
    logic       above_bad;
    logic [7:0] lane_k;
    always_comb begin
        k_o = '0;
        for (int i = 7; i >= 0; i--)
            if (ctrl_i[i]) k_o = 3'(i);
        lane_k = data_i[{k_o, 3'b000} +: 8];
        above_bad = 1'b0;
        for (int i = 0; i < 8; i++)
            if (i > int'(k_o) && data_i[8*i +: 8] != CH_IDLE) above_bad = 1'b1;
        is_term_o  = (ctrl_i != 8'h00) && (lane_k == CH_TERM);
        term_bad_o = (ctrl_i != (8'hFF << k_o)) || above_bad;
    end
endmodule

// File: rtl/xgmii_rx_pkt_mon.sv
// xgmii_rx_pkt_mon: frames XGMII receive packets, checks preamble/terminate/length and counts packets
// Ports: x_clk/reset_ (async active-low); in_vld qualifies data_in/ctrl_in; clr_cnt clears counters;
// in_pkt high in DATA; pkt_done pulses with pkt_len/pkt_err record; pkt_cnt/err_cnt running counts; test tied 0.
module xgmii_rx_pkt_mon
    import xgmii_rx_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        x_clk,
    input  logic        reset_,
    input  logic        in_vld,
    input  logic [63:0] data_in,
    input  logic [7:0]  ctrl_in,
    input  logic        clr_cnt,
    output logic        in_pkt,
    output logic        pkt_done,
    output logic [15:0] pkt_len,
    output logic [4:0]  pkt_err,
    output logic [31:0] pkt_cnt,
    output logic [31:0] err_cnt,
    output logic        test
);
    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic        sat_q, sat_d;
    logic [4:0]  flg_q, flg_d;
    logic        done_q;
    logic [15:0] pkt_len_q, pkt_len_d;
    logic [4:0]  pkt_err_q, pkt_err_d;
    logic [31:0] pkt_cnt_q, pkt_cnt_d;
    logic [31:0] err_cnt_q, err_cnt_d;
    logic        is_start, pre_bad, is_term, term_bad, close;
    logic [2:0]  k;
    logic [2:0]  close_add;
    logic [4:0]  close_flg;
    logic [16:0] sum8, sum_close;
    logic [15:0] close_len;

    xgmii_term_decode u_term (
        .data_i    (data_in),
        .ctrl_i    (ctrl_in),
        .is_term_o (is_term),
        .k_o       (k),
        .term_bad_o(term_bad)
    );

    assign is_start = (ctrl_in == 8'h01) && (data_in[7:0] == CH_START);
    assign pre_bad  = data_in[63:8] != {CH_SFD, {6{CH_PRE}}};
    assign sum8     = {1'b0, len_q} + 17'd8;
    assign sum_close = {1'b0, len_q} + {14'd0, close_add};
    // Overflow of the final add is treated like accumulator saturation.
    assign close_len = sum_close[16] ? 16'hFFFF : sum_close[15:0];

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        sat_d     = sat_q;
        flg_d     = flg_q;
        close     = 1'b0;
        close_add = '0;
        close_flg = flg_q;
        if (in_vld) begin
            if (is_start) begin
                // In DATA this is a restart: close the old packet flagged CTRL, open the new one.
                close = state_q == ST_DATA;
                close_flg[ERR_CTRL] = 1'b1;
                state_d = ST_DATA;
                len_d = '0;
                sat_d = 1'b0;
                flg_d = '0;
                flg_d[ERR_PRE] = pre_bad;
            end else if (state_q == ST_DATA) begin
                if (ctrl_in == 8'h00 || !is_term) begin
                    len_d = sum8[16] ? 16'hFFFF : sum8[15:0];
                    sat_d = sat_q | sum8[16];
                    flg_d[ERR_CTRL] = flg_q[ERR_CTRL] | (ctrl_in != 8'h00);
                end else begin
                    close = 1'b1;
                    close_add = k;
                    close_flg[ERR_TERM] = flg_q[ERR_TERM] | term_bad;
                    state_d = ST_IDLE;
                end
            end
        end
    end

    always_comb begin
        pkt_len_d = pkt_len_q;
        pkt_err_d = pkt_err_q;
        if (close) begin
            pkt_len_d = close_len;
            pkt_err_d = close_flg;
            pkt_err_d[ERR_RUNT] = close_len < 16'(MIN_LEN);
            pkt_err_d[ERR_LONG] = sat_q | sum_close[16] | (close_len > 16'(MAX_LEN));
        end
        pkt_cnt_d = clr_cnt ? '0 : close ? pkt_cnt_q + 32'd1 : pkt_cnt_q;
        err_cnt_d = clr_cnt ? '0 : (close && pkt_err_d != '0) ? err_cnt_q + 32'd1 : err_cnt_q;
    end

    always_ff @(posedge x_clk or negedge reset_) begin
        if (!reset_) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            sat_q     <= 1'b0;
            flg_q     <= '0;
            done_q    <= 1'b0;
            pkt_len_q <= '0;
            pkt_err_q <= '0;
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            sat_q     <= sat_d;
            flg_q     <= flg_d;
            done_q    <= close;
            pkt_len_q <= pkt_len_d;
            pkt_err_q <= pkt_err_d;
            pkt_cnt_q <= pkt_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign in_pkt   = state_q == ST_DATA;
    assign pkt_done = done_q;
    assign pkt_len  = pkt_len_q;
    assign pkt_err  = pkt_err_q;
    assign pkt_cnt  = pkt_cnt_q;
    assign err_cnt  = err_cnt_q;
    assign test     = 1'b0;
endmodule

// File: tb/tb_xgmii_rx_pkt_mon.sv
// tb_xgmii_rx_pkt_mon: directed self-checking bench for the XGMII receive packet monitor
module tb_xgmii_rx_pkt_mon;
    logic        x_clk = 1'b0;
    logic        reset_ = 1'b0;
    logic        in_vld = 1'b0;
    logic [63:0] data_in = '0;
    logic [7:0]  ctrl_in = 8'hFF;
    logic        clr_cnt = 1'b0;
    logic        in_pkt, pkt_done, test;
    logic [15:0] pkt_len;
    logic [4:0]  pkt_err;
    logic [31:0] pkt_cnt, err_cnt;
    logic        done_seen;
    int          vec = 0;
    int          mis = 0;
    logic [31:0] exp_pkt = 0;
    logic [31:0] exp_err = 0;

    xgmii_rx_pkt_mon dut (
        .x_clk(x_clk), .reset_(reset_), .in_vld(in_vld), .data_in(data_in), .ctrl_in(ctrl_in),
        .clr_cnt(clr_cnt), .in_pkt(in_pkt), .pkt_done(pkt_done), .pkt_len(pkt_len),
        .pkt_err(pkt_err), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .test(test)
    );

    always #5 x_clk = ~x_clk;

    task automatic word(input logic [63:0] d, input logic [7:0] c, input int rep);
        data_in = d;
        ctrl_in = c;
        in_vld = 1'b1;
        @(negedge x_clk);
        done_seen = pkt_done;
        in_vld = 1'b0;
        repeat (rep - 1) @(negedge x_clk);
    endtask

    task automatic start(input logic [7:0] sfd, input int rep);
        word({sfd, {6{8'h55}}, 8'hFB}, 8'h01, rep);
    endtask

    task automatic data(input int n, input int rep);
        for (int i = 0; i < n; i++) word({8{8'(i + 16)}}, 8'h00, rep);
    endtask

    task automatic term(input int n, input int rep);
        logic [63:0] d;
        for (int i = 0; i < 8; i++) d[8*i +: 8] = i < n ? 8'hA0 + 8'(i) : i == n ? 8'hFD : 8'h07;
        word(d, 8'hFF << n, rep);
    endtask

    task automatic counts(input string name);
        vec++; if (pkt_cnt !== exp_pkt) begin mis++; $display("FAIL %s pkt_cnt got %0d want %0d", name, pkt_cnt, exp_pkt); end
        vec++; if (err_cnt !== exp_err) begin mis++; $display("FAIL %s err_cnt got %0d want %0d", name, err_cnt, exp_err); end
    endtask

    task automatic test_reset;
        #2;
        vec++; if (pkt_done !== 1'b0) begin mis++; $display("FAIL rst_done got %b want 0", pkt_done); end
        vec++; if (in_pkt !== 1'b0) begin mis++; $display("FAIL rst_in_pkt got %b want 0", in_pkt); end
        vec++; if (pkt_len !== 16'd0) begin mis++; $display("FAIL rst_len got %0d want 0", pkt_len); end
        vec++; if (pkt_err !== 5'd0) begin mis++; $display("FAIL rst_err got %b want 0", pkt_err); end
        vec++; if (test !== 1'b0) begin mis++; $display("FAIL rst_test got %b want 0", test); end
        counts("rst");
        @(negedge x_clk);
        reset_ = 1'b1;
        repeat (2) @(negedge x_clk);
    endtask

    task automatic test_good64;
        start(8'hD5, 1);
        vec++; if (in_pkt !== 1'b1) begin mis++; $display("FAIL good_in_pkt got %b want 1", in_pkt); end
        data(8, 1);
        term(0, 1);
        exp_pkt++;
        vec++; if (done_seen !== 1'b1) begin mis++; $display("FAIL good_done got %b want 1", done_seen); end
        vec++; if (pkt_len !== 16'd64) begin mis++; $display("FAIL good_len got %0d want 64", pkt_len); end
        vec++; if (pkt_err !== 5'b00000) begin mis++; $display("FAIL good_err got %b want 00000", pkt_err); end
        vec++; if (in_pkt !== 1'b0) begin mis++; $display("FAIL good_in_pkt_end got %b want 0", in_pkt); end
        counts("good");
        @(negedge x_clk);
        vec++; if (pkt_done !== 1'b0 || pkt_len !== 16'd64) begin mis++; $display("FAIL good_pulse done %b len %0d want 0 64", pkt_done, pkt_len); end
    endtask

    task automatic test_odd;
        start(8'hD5, 1);
        data(7, 1);
        term(3, 1);
        exp_pkt++; exp_err++;
        vec++; if (pkt_len !== 16'd59) begin mis++; $display("FAIL odd_len got %0d want 59", pkt_len); end
        vec++; if (pkt_err !== 5'b01000) begin mis++; $display("FAIL odd_err got %b want 01000", pkt_err); end
        counts("odd");
    endtask

    task automatic test_bad_pre;
        start(8'hD4, 1);
        word({56'h0, 8'hFE}, 8'h01, 1);
        data(7, 1);
        term(0, 1);
        exp_pkt++; exp_err++;
        vec++; if (pkt_len !== 16'd64) begin mis++; $display("FAIL badpre_len got %0d want 64", pkt_len); end
        vec++; if (pkt_err !== 5'b00101) begin mis++; $display("FAIL badpre_err got %b want 00101", pkt_err); end
        counts("badpre");
    endtask

    task automatic test_restart;
        for (int r = 1; r <= 4; r += 3) begin
            start(8'hD5, r);
            data(8, r);
            start(8'hD5, r);
            exp_pkt++; exp_err++;
            vec++; if (done_seen !== 1'b1) begin mis++; $display("FAIL restart_done rep %0d got %b want 1", r, done_seen); end
            vec++; if (pkt_len !== 16'd64) begin mis++; $display("FAIL restart_len rep %0d got %0d want 64", r, pkt_len); end
            vec++; if (pkt_err !== 5'b00100) begin mis++; $display("FAIL restart_err rep %0d got %b want 00100", r, pkt_err); end
            vec++; if (in_pkt !== 1'b1) begin mis++; $display("FAIL restart_in_pkt rep %0d got %b want 1", r, in_pkt); end
            data(9, r);
            term(4, r);
            exp_pkt++;
            vec++; if (done_seen !== 1'b1) begin mis++; $display("FAIL restart2_done rep %0d got %b want 1", r, done_seen); end
            vec++; if (pkt_len !== 16'd76) begin mis++; $display("FAIL restart2_len rep %0d got %0d want 76", r, pkt_len); end
            vec++; if (pkt_err !== 5'b00000) begin mis++; $display("FAIL restart2_err rep %0d got %b want 00000", r, pkt_err); end
            vec++; if (in_pkt !== 1'b0) begin mis++; $display("FAIL restart2_in_pkt rep %0d got %b want 0", r, in_pkt); end
            counts("restart");
        end
    endtask

    task automatic test_long;
        start(8'hD5, 1);
        data(200, 1);
        term(0, 1);
        exp_pkt++; exp_err++;
        vec++; if (pkt_len !== 16'd1600) begin mis++; $display("FAIL long_len got %0d want 1600", pkt_len); end
        vec++; if (pkt_err !== 5'b10000) begin mis++; $display("FAIL long_err got %b want 10000", pkt_err); end
        counts("long");
    endtask

    task automatic test_back_to_back;
        start(8'hD5, 1);
        data(8, 1);
        term(0, 1);
        exp_pkt++;
        vec++; if (done_seen !== 1'b1 || pkt_len !== 16'd64) begin mis++; $display("FAIL b2b_first done %b len %0d want 1 64", done_seen, pkt_len); end
        start(8'hD5, 1);
        vec++; if (pkt_done !== 1'b0 || in_pkt !== 1'b1) begin mis++; $display("FAIL b2b_start done %b in_pkt %b want 0 1", pkt_done, in_pkt); end
        data(8, 1);
        term(2, 1);
        exp_pkt++;
        vec++; if (done_seen !== 1'b1 || pkt_len !== 16'd66) begin mis++; $display("FAIL b2b_second done %b len %0d want 1 66", done_seen, pkt_len); end
        vec++; if (pkt_err !== 5'b00000) begin mis++; $display("FAIL b2b_err got %b want 00000", pkt_err); end
        counts("b2b");
    endtask

    task automatic test_wrap;
        #1 force dut.pkt_cnt_q = 32'hFFFF_FFFF;
        #1 release dut.pkt_cnt_q;
        start(8'hD5, 1);
        data(8, 1);
        term(0, 1);
        exp_pkt = 32'd0;
        counts("wrap");
    endtask

    task automatic test_clr;
        start(8'hD5, 1);
        clr_cnt = 1'b1;
        term(0, 1);
        clr_cnt = 1'b0;
        exp_pkt = 0; exp_err = 0;
        vec++; if (done_seen !== 1'b1) begin mis++; $display("FAIL clr_done got %b want 1", done_seen); end
        vec++; if (pkt_len !== 16'd0 || pkt_err !== 5'b01000) begin mis++; $display("FAIL clr_rec len %0d err %b want 0 01000", pkt_len, pkt_err); end
        counts("clr");
    endtask

    task automatic test_reset_mid;
        logic any_done;
        start(8'hD5, 1);
        data(3, 1);
        #2 reset_ = 1'b0;
        #1;
        vec++; if (in_pkt !== 1'b0 || pkt_done !== 1'b0) begin mis++; $display("FAIL rmid_ctl in_pkt %b done %b want 0 0", in_pkt, pkt_done); end
        vec++; if (pkt_len !== 16'd0 || pkt_err !== 5'd0) begin mis++; $display("FAIL rmid_rec len %0d err %b want 0 0", pkt_len, pkt_err); end
        vec++; if (pkt_cnt !== 32'd0 || err_cnt !== 32'd0) begin mis++; $display("FAIL rmid_cnt pkt %0d err %0d want 0 0", pkt_cnt, err_cnt); end
        @(negedge x_clk);
        reset_ = 1'b1;
        any_done = 1'b0;
        data(2, 1);
        any_done |= done_seen;
        term(0, 1);
        any_done |= done_seen;
        @(negedge x_clk);
        any_done |= pkt_done;
        vec++; if (any_done !== 1'b0 || in_pkt !== 1'b0) begin mis++; $display("FAIL rmid_after done %b in_pkt %b want 0 0", any_done, in_pkt); end
    endtask

    initial begin
        test_reset;
        test_good64;
        test_odd;
        test_bad_pre;
        test_restart;
        test_long;
        test_back_to_back;
        test_wrap;
        test_clr;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end
endmodule
